// File: rtl/graphite_cmd_pkg.sv
// Shared command-word definitions for the rasterizer command path:
// field widths and positions, the unpacker state type and the header layout.
package graphite_cmd_pkg;

    localparam int CMD_WORD_W  = 32;
    localparam int CMD_OP_W    = 8;
    localparam int CMD_RSV_W   = 4;
    localparam int CMD_LEN_W   = 4;
    localparam int CMD_IMM_W   = 16;

    localparam int CMD_OP_LSB  = 24;
    localparam int CMD_RSV_LSB = 20;
    localparam int CMD_LEN_LSB = 16;
    localparam int CMD_IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        SKIP = 3'd3,
        OUT  = 3'd4
    } cmd_unpack_state_t;

    typedef struct packed {
        logic [CMD_OP_W-1:0]  opcode;
        logic [CMD_RSV_W-1:0] rsv;
        logic [CMD_LEN_W-1:0] len;
        logic [CMD_IMM_W-1:0] imm;
    } cmd_hdr_t;

    // Split a raw FIFO word into header fields using the named bit positions.
    function automatic cmd_hdr_t unpack_hdr(input logic [CMD_WORD_W-1:0] w);
        cmd_hdr_t h;
        h.opcode = w[CMD_OP_LSB  +: CMD_OP_W];
        h.rsv    = w[CMD_RSV_LSB +: CMD_RSV_W];
        h.len    = w[CMD_LEN_LSB +: CMD_LEN_W];
        h.imm    = w[CMD_IMM_LSB +: CMD_IMM_W];
        return h;
    endfunction

endpackage

// File: rtl/cmd_unpacker.sv
// Reader-side command parser for the async command FIFO.
// Pulls a header word plus its payload words, tracking the FIFO's one-cycle
// read latency with a pending flag, and presents whole commands on a
// valid/ready port. Oversized commands are flagged and drained silently.
module cmd_unpacker
    import graphite_cmd_pkg::*;
#(
    parameter int MAX_PAYLOAD = 4
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic [CMD_WORD_W-1:0]       fifo_q_i,
    input  logic                        fifo_empty_i,
    output logic                        fifo_deq_o,
    output logic                        cmd_valid_o,
    input  logic                        cmd_ready_i,
    output logic [CMD_OP_W-1:0]         cmd_opcode_o,
    output logic [CMD_IMM_W-1:0]        cmd_imm_o,
    output logic [CMD_LEN_W-1:0]        cmd_len_o,
    output logic [32*MAX_PAYLOAD-1:0]   cmd_payload_o,
    output logic                        err_len_o
);

    localparam logic [CMD_LEN_W-1:0] MAX_LEN = CMD_LEN_W'(MAX_PAYLOAD);

    cmd_unpack_state_t     state_q, state_d;
    logic                  pend_q;
    logic [CMD_LEN_W-1:0]  tgt_len_q, tgt_len_d;
    logic [CMD_LEN_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CMD_LEN_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [CMD_OP_W-1:0]   opcode_q, opcode_d;
    logic [CMD_IMM_W-1:0]  imm_q, imm_d;
    logic [CMD_LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [CMD_WORD_W-1:0] payload_q [MAX_PAYLOAD];
    logic [CMD_WORD_W-1:0] payload_d [MAX_PAYLOAD];

    cmd_hdr_t              hdr_s;
    logic                  deq_s;
    logic                  deq_acc_s;
    logic                  hdr_rsv_unused;

    // Reserved header bits carry no meaning for this block.
    assign hdr_rsv_unused = ^hdr_s.rsv;

    // Dequeue is suppressed while reset is held so nothing is pulled into a
    // block that is about to forget it.
    assign fifo_deq_o = deq_s & ~rst_i;
    assign deq_acc_s  = fifo_deq_o & ~fifo_empty_i;

    // Next-state, counters, header latch and payload capture.
    always_comb begin
        hdr_s     = unpack_hdr(fifo_q_i);
        state_d   = state_q;
        tgt_len_d = tgt_len_q;
        req_cnt_d = req_cnt_q;
        rcv_cnt_d = rcv_cnt_q;
        opcode_d  = opcode_q;
        imm_d     = imm_q;
        cmd_len_d = cmd_len_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        deq_s     = 1'b0;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            payload_d[k] = payload_q[k];
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty_i) begin
                    deq_s   = 1'b1;
                    state_d = HDR;
                end else begin
                    state_d = IDLE;
                end
            end

            HDR: begin
                if (pend_q) begin
                    tgt_len_d = hdr_s.len;
                    rcv_cnt_d = 4'd0;
                    if (hdr_s.len > MAX_LEN) begin
                        // Oversized: flag once and drain its words without output.
                        err_d     = 1'b1;
                        deq_s     = ~fifo_empty_i;
                        req_cnt_d = {3'd0, ~fifo_empty_i};
                        state_d   = SKIP;
                    end else if (hdr_s.len == 4'd0) begin
                        opcode_d  = hdr_s.opcode;
                        imm_d     = hdr_s.imm;
                        cmd_len_d = 4'd0;
                        req_cnt_d = 4'd0;
                        valid_d   = 1'b1;
                        state_d   = OUT;
                    end else begin
                        // First payload request overlaps header decode: no bubble.
                        opcode_d  = hdr_s.opcode;
                        imm_d     = hdr_s.imm;
                        cmd_len_d = hdr_s.len;
                        deq_s     = ~fifo_empty_i;
                        req_cnt_d = {3'd0, ~fifo_empty_i};
                        state_d   = PAY;
                    end
                end else begin
                    state_d = HDR;
                end
            end

            PAY: begin
                if ((req_cnt_q < tgt_len_q) && !fifo_empty_i) begin
                    deq_s     = 1'b1;
                    req_cnt_d = req_cnt_q + 4'd1;
                end else begin
                    deq_s     = 1'b0;
                end
                if (pend_q) begin
                    for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        if (rcv_cnt_q == CMD_LEN_W'(k)) begin
                            payload_d[k] = fifo_q_i;
                        end else begin
                            payload_d[k] = payload_q[k];
                        end
                    end
                    rcv_cnt_d = rcv_cnt_q + 4'd1;
                    if (rcv_cnt_q == tgt_len_q - 4'd1) begin
                        valid_d = 1'b1;
                        state_d = OUT;
                    end else begin
                        state_d = PAY;
                    end
                end else begin
                    state_d = PAY;
                end
            end

            SKIP: begin
                if ((req_cnt_q < tgt_len_q) && !fifo_empty_i) begin
                    deq_s     = 1'b1;
                    req_cnt_d = req_cnt_q + 4'd1;
                end else begin
                    deq_s     = 1'b0;
                end
                if (pend_q) begin
                    rcv_cnt_d = rcv_cnt_q + 4'd1;
                    if (rcv_cnt_q == tgt_len_q - 4'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SKIP;
                    end
                end else begin
                    state_d = SKIP;
                end
            end

            OUT: begin
                if (cmd_ready_i) begin
                    valid_d = 1'b0;
                    for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        payload_d[k] = '0;
                    end
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = OUT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, read-latency tracker and registered command outputs.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            tgt_len_q <= 4'd0;
            req_cnt_q <= 4'd0;
            rcv_cnt_q <= 4'd0;
            opcode_q  <= 8'd0;
            imm_q     <= 16'd0;
            cmd_len_q <= 4'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                payload_q[k] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            pend_q    <= deq_acc_s;
            tgt_len_q <= tgt_len_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            opcode_q  <= opcode_d;
            imm_q     <= imm_d;
            cmd_len_q <= cmd_len_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                payload_q[k] <= payload_d[k];
            end
        end
    end

    assign cmd_valid_o  = valid_q;
    assign cmd_opcode_o = opcode_q;
    assign cmd_imm_o    = imm_q;
    assign cmd_len_o    = cmd_len_q;
    assign err_len_o    = err_q;

    for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_pl
        assign cmd_payload_o[32*g +: 32] = payload_q[g];
    end

endmodule

// File: tb/tb_cmd_unpacker.sv
// Bench for cmd_unpacker: a behavioural FIFO with one-cycle read latency
// feeds the DUT; a stream parser model predicts commands and length errors.
module tb_cmd_unpacker;

    localparam int MAXP = 4;
    localparam int PW   = 32 * MAXP;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   fifo_q;
    logic          fifo_empty;
    logic          fifo_deq;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_opcode;
    logic [15:0]   cmd_imm;
    logic [3:0]    cmd_len;
    logic [PW-1:0] cmd_payload;
    logic          err_len;

    cmd_unpacker #(.MAX_PAYLOAD(MAXP)) dut (
        .clk          (clk),
        .rst_i        (rst),
        .fifo_q_i     (fifo_q),
        .fifo_empty_i (fifo_empty),
        .fifo_deq_o   (fifo_deq),
        .cmd_valid_o  (cmd_valid),
        .cmd_ready_i  (cmd_ready),
        .cmd_opcode_o (cmd_opcode),
        .cmd_imm_o    (cmd_imm),
        .cmd_len_o    (cmd_len),
        .cmd_payload_o(cmd_payload),
        .err_len_o    (err_len)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [31:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int deq_total = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_deq && !fifo_empty) begin
            fifo_q    <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
            deq_total <= deq_total + 1;
        end
    end

    // ---------------- stream model ----------------
    typedef struct {
        logic [7:0]    op;
        logic [15:0]   imm;
        logic [3:0]    len;
        logic [PW-1:0] pl;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t m_cur;
    int   m_need = 0;
    int   m_cnt  = 0;
    int   m_skip = 0;
    int   err_exp = 0;
    int   err_seen = 0;
    int   got_cnt = 0;

    int   checks = 0;
    int   errors = 0;

    logic [7:0]    last_op;
    logic [15:0]   last_imm;
    logic [3:0]    last_len;
    logic [PW-1:0] last_pl;

    task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    // Interpret one word of the command stream the way the reader should.
    task automatic model_word(input logic [31:0] w);
        int l;
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_need > 0) begin
            m_cur.pl[32*m_cnt +: 32] = w;
            m_cnt++;
            m_need--;
            if (m_need == 0) exp_q.push_back(m_cur);
        end else begin
            l = int'(w[19:16]);
            if (l > MAXP) begin
                err_exp++;
                m_skip = l;
            end else begin
                m_cur.op  = w[31:24];
                m_cur.imm = w[15:0];
                m_cur.len = w[19:16];
                m_cur.pl  = '0;
                m_cnt     = 0;
                if (l == 0) exp_q.push_back(m_cur);
                else m_need = l;
            end
        end
    endtask

    task automatic model_reset();
        m_need = 0;
        m_skip = 0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
        model_word(w);
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                check("deq_while_empty", fifo_deq & fifo_empty, 1'b0);
                if (err_len) err_seen++;
                if (cmd_valid) begin
                    check("no_deq_in_out", fifo_deq, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", cmd_valid, 1'b0);
                    end else begin
                        check("cmd_opcode", cmd_opcode, exp_q[0].op);
                        check("cmd_imm", cmd_imm, exp_q[0].imm);
                        check("cmd_len", cmd_len, exp_q[0].len);
                        check("cmd_payload", cmd_payload, exp_q[0].pl);
                        if (cmd_ready) begin
                            last_op  = cmd_opcode;
                            last_imm = cmd_imm;
                            last_len = cmd_len;
                            last_pl  = cmd_payload;
                            void'(exp_q.pop_front());
                            got_cnt++;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || cmd_valid || !fifo_empty || m_need != 0 || m_skip != 0) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        repeat (2) @(negedge clk);
        check({nm, "_timeout"}, n >= 200, 1'b0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_valid"}, cmd_valid, 1'b0);
        check({nm, "_deq"}, fifo_deq, 1'b0);
        check({nm, "_err"}, err_len, 1'b0);
        check({nm, "_opcode"}, cmd_opcode, 8'h00);
        check({nm, "_imm"}, cmd_imm, 16'h0000);
        check({nm, "_len"}, cmd_len, 4'h0);
        check({nm, "_payload"}, cmd_payload, '0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat;
        int d0;
        int e0;
        int g0;
        logic [PW-1:0] exp_pl;

        rst = 1'b1;
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_all_zero("post_reset");

        // 1: len-3 command, latency from header dequeue
        @(negedge clk);
        push(32'h12030ABC); push(32'h1); push(32'h2); push(32'h3);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #2;
            if (cmd_valid) begin
                lat = k;
                break;
            end
        end
        check("t1_latency", lat, 5);
        wait_idle("t1");
        exp_pl = {32'd0, 32'd3, 32'd2, 32'd1};
        check("t1_opcode_lit", last_op, 8'h12);
        check("t1_imm_lit", last_imm, 16'h0ABC);
        check("t1_len_lit", last_len, 4'd3);
        check("t1_payload_lit", last_pl, exp_pl);

        // 2: zero-length command
        @(negedge clk);
        push(32'h7F00BEEF);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #2;
            if (cmd_valid) begin
                lat = k;
                break;
            end
        end
        check("t2_latency", lat, 2);
        wait_idle("t2");
        check("t2_opcode_lit", last_op, 8'h7F);
        check("t2_imm_lit", last_imm, 16'hBEEF);
        check("t2_payload_lit", last_pl, '0);

        // 3: oversized header is flagged and skipped
        e0 = err_seen;
        @(negedge clk);
        push(32'h33070000);
        for (int k = 0; k < 7; k++) push(32'hDEAD0000 + k);
        push(32'h01010001); push(32'h000000AA);
        wait_idle("t3");
        check("t3_err_once", err_seen - e0, 1);
        check("t3_err_model", err_seen, err_exp);
        check("t3_opcode_lit", last_op, 8'h01);
        check("t3_pl0_lit", last_pl[31:0], 32'h000000AA);
        check("t3_len_lit", last_len, 4'd1);

        // 4: writer stalls mid-payload of a full-length command
        d0 = deq_total;
        @(negedge clk);
        push(32'h21040042); push(32'hA0); push(32'hA1);
        repeat (5) @(negedge clk);
        push(32'hA2); push(32'hA3);
        wait_idle("t4");
        exp_pl = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        check("t4_payload_lit", last_pl, exp_pl);
        check("t4_deq_count", deq_total - d0, 5);

        // 5: backpressure with more commands queued
        g0 = got_cnt;
        @(negedge clk);
        cmd_ready = 1'b0;
        push(32'h40011111); push(32'hA1);
        push(32'h41000002);
        push(32'h42022222); push(32'hC1); push(32'hC2);
        push(32'h43010003); push(32'hD1);
        lat = 0;
        while (!cmd_valid && lat < 50) begin
            @(negedge clk);
            #2;
            lat++;
        end
        check("t5_valid_timeout", lat >= 50, 1'b0);
        d0 = deq_total;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #2;
            check("t5_hold_deq", fifo_deq, 1'b0);
            check("t5_hold_valid", cmd_valid, 1'b1);
            check("t5_hold_opcode", cmd_opcode, 8'h40);
        end
        check("t5_no_reads", deq_total - d0, 0);
        @(negedge clk);
        cmd_ready = 1'b1;
        wait_idle("t5");
        check("t5_delivered", got_cnt - g0, 4);
        check("t5_last_opcode", last_op, 8'h43);
        check("t5_last_pl0", last_pl[31:0], 32'hD1);

        // 6: reset in the middle of a payload
        @(negedge clk);
        push(32'h66040000); push(32'h11); push(32'h22);
        repeat (8) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t6_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(32'h05010000); push(32'h55);
        wait_idle("t6");
        check("t6_opcode_lit", last_op, 8'h05);
        check("t6_len_lit", last_len, 4'd1);
        check("t6_pl0_lit", last_pl[31:0], 32'h55);
        check("t6_pl_upper", last_pl[PW-1:32], '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
